// File: rtl/sfx_scheduler_if.sv
// Request/status bundle between game logic and the sound-effect scheduler.
interface sfx_scheduler_if;
   logic        en;
   logic        mute;
   logic [2:0]  req;
   logic [21:0] note_div;
   logic [2:0]  grant;
   logic        busy;
   logic        done;

   modport master (output en, mute, req, input note_div, grant, busy, done);
   modport slave  (input en, mute, req, output note_div, grant, busy, done);
endinterface

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound-effect sequencer driving note_gen dividers from a 4-note ROM per effect.
// Optional preemption by a strictly higher-priority request: define SFX_PREEMPT_EN.
module sfx_scheduler #(
   parameter int TICK_DIV  = 2_500_000,
   parameter int GAP_TICKS = 1
) (
   input logic            clk,
   input logic            rst,
   sfx_scheduler_if.slave bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PLAY = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   logic [1:0]    state_reg;
   logic [2:0]    pending_reg;
   logic [2:0]    grant_reg;
   logic [1:0]    sel_reg;
   logic [1:0]    idx_reg;
   logic [TW-1:0] tick_reg;
   logic [7:0]    cnt_reg;
   logic          done_reg;

   logic [2:0]    pend_eff;
   logic [21:0]   rom_note;
   logic [3:0]    rom_dur;
   logic [7:0]    limit;
   logic          tick_end;
   logic          phase_end;
   logic          preempt;

   function automatic logic [1:0] top_bit(input logic [2:0] v);
      if (v[2])      return 2'd2;
      else if (v[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   // A request arriving this cycle counts immediately so grant lands two cycles later.
   assign pend_eff = pending_reg | bus.req;

   always_comb begin
      rom_note = 22'd0;
      rom_dur  = 4'd0;
      case ({sel_reg, idx_reg})
         4'h0: begin rom_note = 22'd113636; rom_dur = 4'd2;  end
         4'h1: begin rom_note = 22'd101214; rom_dur = 4'd2;  end
         4'h2: begin rom_note = 22'd90192;  rom_dur = 4'd2;  end
         4'h3: begin rom_note = 22'd75873;  rom_dur = 4'd4;  end
         4'h4: begin rom_note = 22'd151515; rom_dur = 4'd3;  end
         4'h5: begin rom_note = 22'd0;      rom_dur = 4'd1;  end
         4'h6: begin rom_note = 22'd151515; rom_dur = 4'd3;  end
         4'h7: begin rom_note = 22'd0;      rom_dur = 4'd1;  end
         4'h8: begin rom_note = 22'd191571; rom_dur = 4'd6;  end
         4'h9: begin rom_note = 22'd202478; rom_dur = 4'd6;  end
         4'hA: begin rom_note = 22'd227272; rom_dur = 4'd6;  end
         4'hB: begin rom_note = 22'd255102; rom_dur = 4'd12; end
         default: begin rom_note = 22'd0; rom_dur = 4'd0; end
      endcase
   end

   always_comb begin
      limit     = (state_reg == ST_PLAY) ? {4'd0, rom_dur} : 8'(GAP_TICKS);
      tick_end  = (tick_reg == TW'(TICK_DIV - 1));
      phase_end = tick_end && (cnt_reg == limit - 8'd1);
   end

`ifdef SFX_PREEMPT_EN
   always_comb begin
      preempt = ((state_reg == ST_PLAY) || (state_reg == ST_GAP)) &&
                (|(pend_eff & {grant_reg[1] | grant_reg[0], grant_reg[0], 1'b0}));
   end
`else
   always_comb begin
      preempt = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         pending_reg <= 3'd0;
         grant_reg   <= 3'd0;
         sel_reg     <= 2'd0;
         idx_reg     <= 2'd0;
         tick_reg    <= '0;
         cnt_reg     <= 8'd0;
         done_reg    <= 1'b0;
      end else begin
         done_reg    <= 1'b0;
         pending_reg <= pend_eff;
         if (bus.en) begin
            case (state_reg)
               ST_IDLE: begin
                  if (|pend_eff) begin
                     sel_reg   <= top_bit(pend_eff);
                     state_reg <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  grant_reg   <= 3'(3'b001 << sel_reg);
                  // Keep a same-cycle re-request so the effect replays afterwards.
                  pending_reg <= (pending_reg & ~3'(3'b001 << sel_reg)) | bus.req;
                  idx_reg     <= 2'd0;
                  tick_reg    <= '0;
                  cnt_reg     <= 8'd0;
                  state_reg   <= ST_PLAY;
               end
               default: begin
                  if (preempt) begin
                     sel_reg   <= top_bit(pend_eff);
                     state_reg <= ST_LOAD;
                  end else if (tick_end) begin
                     tick_reg <= '0;
                     if (phase_end) begin
                        cnt_reg <= 8'd0;
                        if (state_reg == ST_GAP) begin
                           idx_reg   <= idx_reg + 2'd1;
                           state_reg <= ST_PLAY;
                        end else if (idx_reg == 2'd3) begin
                           grant_reg <= 3'd0;
                           done_reg  <= 1'b1;
                           state_reg <= ST_IDLE;
                        end else begin
                           state_reg <= ST_GAP;
                        end
                     end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                     end
                  end else begin
                     tick_reg <= tick_reg + TW'(1);
                  end
               end
            endcase
         end
      end
   end

   assign bus.note_div = (state_reg == ST_PLAY && bus.en && !bus.mute) ? rom_note : 22'd0;
   assign bus.grant    = grant_reg;
   assign bus.busy     = |grant_reg;
   assign bus.done     = done_reg;
endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed table-driven bench for sfx_scheduler with TICK_DIV=4, GAP_TICKS=1.
module tb_sfx_scheduler;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   sfx_scheduler_if bus();

   sfx_scheduler #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          n;
      logic [2:0]  req;
      logic        en;
      logic        mute;
      logic [21:0] note;
      logic [2:0]  grant;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t rows[$];

   int unsigned note_tab [0:2][0:3] = '{
      '{113636, 101214, 90192, 75873},
      '{151515, 0, 151515, 0},
      '{191571, 202478, 227272, 255102}};
   int unsigned dur_tab [0:2][0:3] = '{
      '{2, 2, 2, 4},
      '{3, 1, 3, 1},
      '{6, 6, 6, 12}};

   function automatic void add(input int n, input logic [2:0] req, input logic en,
                               input logic mute, input logic [21:0] note,
                               input logic [2:0] grant, input logic busy, input logic done);
      vec_t v;
      v.n = n; v.req = req; v.en = en; v.mute = mute;
      v.note = note; v.grant = grant; v.busy = busy; v.done = done;
      rows.push_back(v);
   endfunction

   // Full uninterrupted playback of effect e from its first PLAY cycle through the done cycle.
   function automatic void add_play(input int e);
      logic [2:0] g;
      g = 3'(1 << e);
      for (int i = 0; i < 4; i++) begin
         add(int'(dur_tab[e][i]) * 4, 3'b000, 1'b1, 1'b0, 22'(note_tab[e][i]), g, 1'b1, 1'b0);
         if (i < 3) add(4, 3'b000, 1'b1, 1'b0, 22'd0, g, 1'b1, 1'b0);
      end
      add(1, 3'b000, 1'b1, 1'b0, 22'd0, 3'b000, 1'b0, 1'b1);
   endfunction

   function automatic void add_idle(input int n);
      add(n, 3'b000, 1'b1, 1'b0, 22'd0, 3'b000, 1'b0, 1'b0);
   endfunction

   function automatic void build_table();
      // Single jump effect, two-cycle grant latency.
      add_idle(2);
      add(1, 3'b001, 1'b1, 1'b0, 22'd0, 3'b000, 1'b0, 1'b0);
      add_idle(1);
      add_play(0);
      add_idle(2);
      // All three at once: served in priority order, LOAD follows each done.
      add(1, 3'b111, 1'b1, 1'b0, 22'd0, 3'b000, 1'b0, 1'b0);
      add_idle(1);
      add_play(2);
      add_idle(1);
      add_play(1);
      add_idle(1);
      add_play(0);
      add_idle(2);
      // Higher request while E0 plays.
      add(1, 3'b001, 1'b1, 1'b0, 22'd0, 3'b000, 1'b0, 1'b0);
      add_idle(1);
      add(2, 3'b000, 1'b1, 1'b0, 22'd113636, 3'b001, 1'b1, 1'b0);
      add(1, 3'b100, 1'b1, 1'b0, 22'd113636, 3'b001, 1'b1, 1'b0);
`ifdef SFX_PREEMPT_EN
      add(1, 3'b000, 1'b1, 1'b0, 22'd0, 3'b001, 1'b1, 1'b0);
      add_play(2);
`else
      add(5, 3'b000, 1'b1, 1'b0, 22'd113636, 3'b001, 1'b1, 1'b0);
      add(4, 3'b000, 1'b1, 1'b0, 22'd0,      3'b001, 1'b1, 1'b0);
      add(8, 3'b000, 1'b1, 1'b0, 22'd101214, 3'b001, 1'b1, 1'b0);
      add(4, 3'b000, 1'b1, 1'b0, 22'd0,      3'b001, 1'b1, 1'b0);
      add(8, 3'b000, 1'b1, 1'b0, 22'd90192,  3'b001, 1'b1, 1'b0);
      add(4, 3'b000, 1'b1, 1'b0, 22'd0,      3'b001, 1'b1, 1'b0);
      add(16, 3'b000, 1'b1, 1'b0, 22'd75873, 3'b001, 1'b1, 1'b0);
      add(1, 3'b000, 1'b1, 1'b0, 22'd0,      3'b000, 1'b0, 1'b1);
      add_idle(1);
      add_play(2);
`endif
      add_idle(2);
      // Pause mid-note for 20 cycles, then mute through the last note and done.
      add(1, 3'b001, 1'b1, 1'b0, 22'd0, 3'b000, 1'b0, 1'b0);
      add_idle(1);
      add(3,  3'b000, 1'b1, 1'b0, 22'd113636, 3'b001, 1'b1, 1'b0);
      add(20, 3'b000, 1'b0, 1'b0, 22'd0,      3'b001, 1'b1, 1'b0);
      add(5,  3'b000, 1'b1, 1'b0, 22'd113636, 3'b001, 1'b1, 1'b0);
      add(4,  3'b000, 1'b1, 1'b0, 22'd0,      3'b001, 1'b1, 1'b0);
      add(8,  3'b000, 1'b1, 1'b0, 22'd101214, 3'b001, 1'b1, 1'b0);
      add(4,  3'b000, 1'b1, 1'b0, 22'd0,      3'b001, 1'b1, 1'b0);
      add(8,  3'b000, 1'b1, 1'b0, 22'd90192,  3'b001, 1'b1, 1'b0);
      add(4,  3'b000, 1'b1, 1'b0, 22'd0,      3'b001, 1'b1, 1'b0);
      add(16, 3'b000, 1'b1, 1'b1, 22'd0,      3'b001, 1'b1, 1'b0);
      add(1,  3'b000, 1'b1, 1'b1, 22'd0,      3'b000, 1'b0, 1'b1);
      // Request latched while paused in IDLE, granted once en returns.
      add(1, 3'b010, 1'b0, 1'b0, 22'd0, 3'b000, 1'b0, 1'b0);
      add(3, 3'b000, 1'b0, 1'b0, 22'd0, 3'b000, 1'b0, 1'b0);
      add_idle(2);
      // Re-request of the playing effect replays it after done.
      add(2,  3'b000, 1'b1, 1'b0, 22'd151515, 3'b010, 1'b1, 1'b0);
      add(1,  3'b010, 1'b1, 1'b0, 22'd151515, 3'b010, 1'b1, 1'b0);
      add(9,  3'b000, 1'b1, 1'b0, 22'd151515, 3'b010, 1'b1, 1'b0);
      add(12, 3'b000, 1'b1, 1'b0, 22'd0,      3'b010, 1'b1, 1'b0);
      add(12, 3'b000, 1'b1, 1'b0, 22'd151515, 3'b010, 1'b1, 1'b0);
      add(8,  3'b000, 1'b1, 1'b0, 22'd0,      3'b010, 1'b1, 1'b0);
      add(1,  3'b000, 1'b1, 1'b0, 22'd0,      3'b000, 1'b0, 1'b1);
      add_idle(1);
      add_play(1);
      add_idle(2);
   endfunction

   initial begin
      int row_bad;
      bit seen;
      total    = 0;
      bad      = 0;
      rst      = 1'b0;
      bus.en   = 1'b1;
      bus.mute = 1'b0;
      bus.req  = 3'b000;
      build_table();

      repeat (3) @(negedge clk);
      #2;
      total++;
      if ({bus.note_div, bus.grant, bus.busy, bus.done} !== 27'd0) begin
         bad++;
         $display("FAIL reset_state: note_div=%0d grant=%b busy=%b done=%b, want all zero",
                  bus.note_div, bus.grant, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b1;

      for (int r = 0; r < rows.size(); r++) begin
         row_bad = 0;
         for (int c = 0; c < rows[r].n; c++) begin
            @(negedge clk);
            bus.req  = rows[r].req;
            bus.en   = rows[r].en;
            bus.mute = rows[r].mute;
            #2;
            total++;
            if ({bus.note_div, bus.grant, bus.busy, bus.done} !==
                {rows[r].note, rows[r].grant, rows[r].busy, rows[r].done}) begin
               bad++;
               row_bad++;
               $display("FAIL row%0d cyc%0d: got note_div=%0d grant=%b busy=%b done=%b, want %0d %b %b %b",
                        r, c, bus.note_div, bus.grant, bus.busy, bus.done,
                        rows[r].note, rows[r].grant, rows[r].busy, rows[r].done);
            end
         end
         $display("row %0d: n=%0d req=%b en=%b mute=%b note_div=%0d grant=%b done=%b -> %0s",
                  r, rows[r].n, rows[r].req, rows[r].en, rows[r].mute, rows[r].note,
                  rows[r].grant, rows[r].done, (row_bad == 0) ? "ok" : "bad");
      end

      // Asynchronous reset in the middle of E2 aborts it without a done pulse.
      @(negedge clk);
      bus.req = 3'b100;
      bus.en  = 1'b1;
      bus.mute = 1'b0;
      @(negedge clk);
      bus.req = 3'b000;
      repeat (40) @(negedge clk);
      #2;
      total++;
      if (bus.grant !== 3'b100 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_grant: grant=%b busy=%b, want 100 1", bus.grant, bus.busy);
      end
      #1 rst = 1'b0;
      #1;
      total++;
      if ({bus.note_div, bus.grant, bus.busy, bus.done} !== 27'd0) begin
         bad++;
         $display("FAIL mid_reset: note_div=%0d grant=%b busy=%b done=%b, want all zero",
                  bus.note_div, bus.grant, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (150) begin
         @(negedge clk);
         #2;
         if (bus.done || bus.busy || bus.note_div != 22'd0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL post_reset_quiet: activity seen=%b, want 0", seen);
      end
      $display("reset mid-E2: aborted -> %0s", seen ? "bad" : "ok");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
